// File: rtl/fft_frame_sequencer_pkg.sv
// Shared types and default sizing for the FFT frame sequencer.
package fft_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2
    } seq_state_e;

    localparam int DEF_W_IN       = 16;
    localparam int DEF_W_OUT      = 32;
    localparam int DEF_GUARD      = 8;
    localparam int DEF_N_FFT      = 1024;
    localparam int DEF_DECIM_LOG2 = 6;
    localparam int DEF_CNT_W      = 16;

endpackage

// File: rtl/fft_frame_sequencer_if.sv
// FFT input stream: valid/ready handshake with frame-last marker.
interface fft_frame_sequencer_if
    import fft_seq_pkg::*;
#(
    parameter int W_OUT = DEF_W_OUT
);

    logic             out_valid;
    logic [W_OUT-1:0] out_data;
    logic             out_last;
    logic             out_ready;

    modport master (output out_valid, output out_data, output out_last, input out_ready);
    modport slave  (input out_valid, input out_data, input out_last, output out_ready);

endinterface

// File: rtl/fft_frame_sequencer_sample_decimator.sv
// Keeps one codec sample in 2^DECIM_LOG2 and widens it to FFT word format:
// sign-extended by GUARD bits, sample in the middle, zero-filled LSBs.
module sample_decimator
    import fft_seq_pkg::*;
#(
    parameter int W_IN       = DEF_W_IN,
    parameter int W_OUT      = DEF_W_OUT,
    parameter int GUARD      = DEF_GUARD,
    parameter int DECIM_LOG2 = DEF_DECIM_LOG2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    in_valid,
    input  logic signed [W_IN-1:0]  in_data,
    output logic                    emit,
    output logic signed [W_OUT-1:0] sample_wide
);

    // A 1-bit counter pinned at zero covers DECIM_LOG2=0 (every sample emits).
    localparam int DEC_W = (DECIM_LOG2 == 0) ? 1 : DECIM_LOG2;
    localparam int ZPAD  = W_OUT - W_IN - GUARD;
    localparam logic [DEC_W-1:0] DEC_MAX = DEC_W'((1 << DECIM_LOG2) - 1);

    logic [DEC_W-1:0] dec;

    function automatic logic signed [W_OUT-1:0] widen(input logic signed [W_IN-1:0] s);
        logic signed [W_OUT-1:0] ext;
        ext = W_OUT'(s);
        return ext <<< ZPAD;
    endfunction

    // Decimation phase counter; held at zero while cleared.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dec <= '0;
        end else if (clear) begin
            dec <= '0;
        end else if (in_valid) begin
            dec <= (dec == DEC_MAX) ? '0 : dec + 1'b1;
        end
    end

    assign emit        = in_valid && !clear && (dec == DEC_MAX);
    assign sample_wide = widen(in_data);

endmodule

// File: rtl/fft_frame_sequencer.sv
// Frames decimated codec samples into N_FFT-word bursts for the FFT, then
// waits for N_FFT result beats before opening the next frame.
module fft_frame_sequencer
    import fft_seq_pkg::*;
#(
    parameter int W_IN       = DEF_W_IN,
    parameter int W_OUT      = DEF_W_OUT,
    parameter int GUARD      = DEF_GUARD,
    parameter int N_FFT      = DEF_N_FFT,
    parameter int DECIM_LOG2 = DEF_DECIM_LOG2,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   in_valid,
    input  logic signed [W_IN-1:0] in_data,
    fft_frame_sequencer_if.master  fft,
    input  logic                   res_beat,
    output logic                   busy,
    output logic                   frame_done,
    output logic [CNT_W-1:0]       frame_cnt,
    output logic [CNT_W-1:0]       drop_cnt
);

    localparam int IC_W = $clog2(N_FFT) + 1;
    localparam logic [IC_W-1:0] N_FULL = IC_W'(N_FFT);
    localparam logic [IC_W-1:0] N_LAST = IC_W'(N_FFT - 1);

    seq_state_e state_q, state_d;

    logic [IC_W-1:0]         issue_cnt;
    logic [IC_W-1:0]         res_cnt;
    logic                    out_valid_q;
    logic                    out_last_q;
    logic signed [W_OUT-1:0] out_data_q;

    logic                    emit;
    logic signed [W_OUT-1:0] sample_wide;

    logic can_issue, load, drop, out_hs, last_hs, res_done, fill_start, res_clear;

    sample_decimator #(
        .W_IN       (W_IN),
        .W_OUT      (W_OUT),
        .GUARD      (GUARD),
        .DECIM_LOG2 (DECIM_LOG2)
    ) u_decim (
        .clk         (clk),
        .reset       (reset),
        .clear       (state_q == IDLE),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .emit        (emit),
        .sample_wide (sample_wide)
    );

    // Frame state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next state: enable is only consulted at frame boundaries.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (enable)   state_d = FILL;
            FILL:    if (last_hs)  state_d = DRAIN;
            DRAIN:   if (res_done) state_d = enable ? FILL : IDLE;
            default:               state_d = IDLE;
        endcase
    end

    // Control decode; a load alongside a handshake replaces the outgoing word.
    always_comb begin
        can_issue  = (state_q == FILL) && emit && (issue_cnt < N_FULL);
        out_hs     = out_valid_q && fft.out_ready;
        load       = can_issue && (!out_valid_q || fft.out_ready);
        drop       = can_issue && out_valid_q && !fft.out_ready;
        last_hs    = (state_q == FILL) && out_hs && out_last_q;
        res_done   = (state_q == DRAIN) && res_beat && (res_cnt == N_LAST);
        fill_start = ((state_q == IDLE) && enable) || (res_done && enable);
        res_clear  = ((state_q == IDLE) && enable) || res_done;
    end

    // Output word register toward the FFT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else if (load) begin
            out_valid_q <= 1'b1;
            out_last_q  <= (issue_cnt == N_LAST);
            out_data_q  <= sample_wide;
        end else if (out_hs) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end
    end

    // Issued-word and result-beat counters for the current frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            issue_cnt <= '0;
            res_cnt   <= '0;
        end else begin
            if (fill_start)  issue_cnt <= '0;
            else if (load)   issue_cnt <= issue_cnt + 1'b1;
            if (res_clear)   res_cnt <= '0;
            else if ((state_q == DRAIN) && res_beat) res_cnt <= res_cnt + 1'b1;
        end
    end

    // Debug statistics and registered status.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy       <= 1'b0;
            frame_done <= 1'b0;
            frame_cnt  <= '0;
            drop_cnt   <= '0;
        end else begin
            busy       <= (state_d != IDLE);
            frame_done <= res_done;
            if (res_done) frame_cnt <= frame_cnt + 1'b1;
            if (drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + 1'b1;
        end
    end

    assign fft.out_valid = out_valid_q;
    assign fft.out_last  = out_last_q;
    assign fft.out_data  = out_data_q;

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Directed bench: full frames at DECIM_LOG2=2/N_FFT=1024, plus a
// back-to-back instance at DECIM_LOG2=0/N_FFT=8.
module tb_fft_frame_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: DECIM_LOG2=2, N_FFT=1024
    logic        rst_a, en_a, iv_a, rb_a;
    logic [15:0] id_a;
    logic        busy_a, fd_a;
    logic [15:0] fcnt_a, dcnt_a;
    fft_frame_sequencer_if #(.W_OUT(32)) fft_a ();

    fft_frame_sequencer #(.DECIM_LOG2(2)) u_dut (
        .clk        (clk),
        .reset      (rst_a),
        .enable     (en_a),
        .in_valid   (iv_a),
        .in_data    (id_a),
        .fft        (fft_a.master),
        .res_beat   (rb_a),
        .busy       (busy_a),
        .frame_done (fd_a),
        .frame_cnt  (fcnt_a),
        .drop_cnt   (dcnt_a)
    );

    // Instance B: DECIM_LOG2=0, N_FFT=8
    logic        rst_b, en_b, iv_b, rb_b;
    logic [15:0] id_b;
    logic        busy_b, fd_b;
    logic [15:0] fcnt_b, dcnt_b;
    fft_frame_sequencer_if #(.W_OUT(32)) fft_b ();

    fft_frame_sequencer #(.DECIM_LOG2(0), .N_FFT(8)) u_b2b (
        .clk        (clk),
        .reset      (rst_b),
        .enable     (en_b),
        .in_valid   (iv_b),
        .in_data    (id_b),
        .fft        (fft_b.master),
        .res_beat   (rb_b),
        .busy       (busy_b),
        .frame_done (fd_b),
        .frame_cnt  (fcnt_b),
        .drop_cnt   (dcnt_b)
    );

    int n_chk = 0;
    int n_pass = 0;

    // Handshake / last / frame_done monitor for instance A (pre-edge values).
    int hs_cnt = 0;
    int last_cnt = 0;
    int last_idx = 0;
    int fd_cnt = 0;
    always @(posedge clk) begin
        if (fft_a.out_valid && fft_a.out_ready) begin
            hs_cnt = hs_cnt + 1;
            if (fft_a.out_last) begin
                last_cnt = last_cnt + 1;
                last_idx = hs_cnt;
            end
        end
        if (fd_a) fd_cnt = fd_cnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_hs(input int target, input int budget);
        int n = 0;
        while (hs_cnt < target && n < budget) begin
            step();
            n++;
        end
    endtask

    logic [15:0] b_in  [8] = '{16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF,
                               16'h1234, 16'hABCD, 16'h0000, 16'h5A5A};
    logic [31:0] b_exp [8] = '{32'h00000100, 32'h007FFF00, 32'hFF800000, 32'hFFFFFF00,
                               32'h00123400, 32'hFFABCD00, 32'h00000000, 32'h005A5A00};

    int base, lbase, fbase, lat, nv;
    logic [31:0] held;
    logic stable;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_a = 1; en_a = 0; iv_a = 0; id_a = '0; rb_a = 0; fft_a.out_ready = 1;
        rst_b = 1; en_b = 0; iv_b = 0; id_b = '0; rb_b = 0; fft_b.out_ready = 1;
        repeat (3) step();

        chk("rst_out_valid",  64'(fft_a.out_valid), 64'd0);
        chk("rst_out_last",   64'(fft_a.out_last),  64'd0);
        chk("rst_out_data",   64'(fft_a.out_data),  64'd0);
        chk("rst_busy",       64'(busy_a),          64'd0);
        chk("rst_frame_done", 64'(fd_a),            64'd0);
        chk("rst_frame_cnt",  64'(fcnt_a),          64'd0);
        chk("rst_drop_cnt",   64'(dcnt_a),          64'd0);

        rst_a = 0; rst_b = 0;
        step();

        // Frame 1: result beats in IDLE and early FILL must be ignored
        rb_a = 1;
        repeat (2) step();
        en_a = 1;
        step();
        chk("f1_busy", 64'(busy_a), 64'd1);
        id_a = 16'h8001; iv_a = 1;
        base = hs_cnt; lbase = last_cnt;
        lat = 0;
        do begin
            step();
            lat++;
        end while (!fft_a.out_valid && lat < 20);
        rb_a = 0;
        chk("f1_first_latency", 64'(lat), 64'd4);
        chk("f1_first_data", 64'(fft_a.out_data), 64'hFF800100);
        chk("f1_first_last", 64'(fft_a.out_last), 64'd0);
        wait_hs(base + 1024, 6000);
        chk("f1_hs_total", 64'(hs_cnt - base), 64'd1024);
        chk("f1_last_count", 64'(last_cnt - lbase), 64'd1);
        chk("f1_last_index", 64'(last_idx - base), 64'd1024);
        chk("f1_drain_valid", 64'(fft_a.out_valid), 64'd0);
        chk("f1_drain_busy", 64'(busy_a), 64'd1);

        // Drain: 1023 beats without completion, 1024th completes
        fbase = fd_cnt;
        rb_a = 1;
        repeat (1023) step();
        chk("f1_no_early_done", 64'(fd_cnt - fbase), 64'd0);
        chk("f1_cnt_before", 64'(fcnt_a), 64'd0);
        step();
        rb_a = 0;
        chk("f1_frame_done", 64'(fd_a), 64'd1);
        chk("f1_frame_cnt", 64'(fcnt_a), 64'd1);
        chk("f1_refill_busy", 64'(busy_a), 64'd1);
        chk("f1_no_drain_issue", 64'(hs_cnt - base), 64'd1024);
        step();
        chk("f1_done_pulse_end", 64'(fd_a), 64'd0);

        // Frame 2: backpressure drops three emits, held word stays stable
        base = hs_cnt; lbase = last_cnt;
        lat = 0;
        while (!fft_a.out_valid && lat < 10) begin
            step();
            lat++;
        end
        fft_a.out_ready = 0;
        id_a = 16'h7FFF;
        held = fft_a.out_data;
        chk("f2_held_data", 64'(held), 64'hFF800100);
        stable = 1'b1;
        repeat (12) begin
            step();
            if (fft_a.out_data !== held || fft_a.out_valid !== 1'b1) stable = 1'b0;
        end
        chk("f2_held_stable", 64'(stable), 64'd1);
        chk("f2_drop_cnt", 64'(dcnt_a), 64'd3);
        fft_a.out_ready = 1;
        repeat (4) step();
        chk("f2_next_valid", 64'(fft_a.out_valid), 64'd1);
        chk("f2_next_data", 64'(fft_a.out_data), 64'h007FFF00);

        // enable falls at sample 500; the frame still finishes
        wait_hs(base + 500, 3000);
        en_a = 0;
        wait_hs(base + 1024, 6000);
        chk("f2_hs_total", 64'(hs_cnt - base), 64'd1024);
        chk("f2_last_count", 64'(last_cnt - lbase), 64'd1);
        chk("f2_last_index", 64'(last_idx - base), 64'd1024);
        chk("f2_drop_final", 64'(dcnt_a), 64'd3);
        rb_a = 1;
        repeat (1024) step();
        rb_a = 0;
        chk("f2_frame_done", 64'(fd_a), 64'd1);
        chk("f2_frame_cnt", 64'(fcnt_a), 64'd2);
        chk("f2_idle_busy", 64'(busy_a), 64'd0);
        base = hs_cnt;
        nv = 0;
        repeat (20) begin
            step();
            if (fft_a.out_valid) nv++;
        end
        chk("idle_no_valid", 64'(nv), 64'd0);
        chk("idle_no_hs", 64'(hs_cnt - base), 64'd0);
        chk("idle_busy", 64'(busy_a), 64'd0);

        // Frame 3: asynchronous reset in the middle of DRAIN
        en_a = 1;
        base = hs_cnt;
        wait_hs(base + 1024, 6000);
        chk("f3_hs_total", 64'(hs_cnt - base), 64'd1024);
        rb_a = 1;
        repeat (100) step();
        rb_a = 0;
        chk("f3_pre_busy", 64'(busy_a), 64'd1);
        chk("f3_pre_frame_cnt", 64'(fcnt_a), 64'd2);
        #3;
        rst_a = 1;
        #1;
        chk("arst_out_valid", 64'(fft_a.out_valid), 64'd0);
        chk("arst_busy", 64'(busy_a), 64'd0);
        chk("arst_frame_cnt", 64'(fcnt_a), 64'd0);
        chk("arst_drop_cnt", 64'(dcnt_a), 64'd0);
        chk("arst_state", 64'(u_dut.state_q), 64'(fft_seq_pkg::IDLE));
        step();
        rst_a = 0; en_a = 0; iv_a = 0;

        // Instance B: one word per cycle, load wins over the handshake
        en_b = 1;
        step();
        iv_b = 1;
        for (int i = 0; i < 8; i++) begin
            id_b = b_in[i];
            step();
            chk("b2b_valid", 64'(fft_b.out_valid), 64'd1);
            chk("b2b_data", 64'(fft_b.out_data), 64'(b_exp[i]));
            chk("b2b_last", 64'(fft_b.out_last), 64'(i == 7));
        end
        id_b = 16'h4444;
        step();
        chk("b2b_drain_valid", 64'(fft_b.out_valid), 64'd0);
        chk("b2b_drain_busy", 64'(busy_b), 64'd1);
        chk("b2b_no_drop", 64'(dcnt_b), 64'd0);
        en_b = 0;
        rb_b = 1;
        repeat (8) step();
        rb_b = 0;
        chk("b2b_frame_done", 64'(fd_b), 64'd1);
        chk("b2b_frame_cnt", 64'(fcnt_b), 64'd1);
        chk("b2b_idle_busy", 64'(busy_b), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fft_frame_sequencer.md
Name: fft_frame_sequencer

Overview:
- Sits between audio_codec_data and fft_stream, in the adc_clk domain.
- Decimates the un-handshaked codec sample stream and widens each kept sample to FFT width.
- Issues exactly N_FFT samples per frame to the FFT under valid/ready, then waits for the FFT to return N_FFT result beats before starting the next frame.
- Counts dropped samples and completed frames for debug/LED display.

Parameters:
- W_IN, 16, codec sample width (two's complement)
- W_OUT, 32, FFT input word width
- GUARD, 8, sign-extension headroom bits above the sample; remaining LSBs are zero-filled
- N_FFT, 1024, samples per frame and result beats per frame; power of two
- DECIM_LOG2, 6, keep one sample in 2^DECIM_LOG2
- CNT_W, 16, width of statistics counters

Ports:
- clk  in  1  sample/FFT clock (adc_clk)
- reset  in  1  asynchronous, active-high reset
- enable  in  1  level; high = run frames continuously
- in_valid  in  1  codec sample strobe; upstream has no backpressure
- in_data  in  W_IN  codec sample
- out_valid  out  1  FFT input valid
- out_data  out  W_OUT  FFT input word
- out_last  out  1  high with the N_FFT-th sample of a frame
- out_ready  in  1  FFT input ready
- res_beat  in  1  one FFT result beat accepted downstream (fft_out valid&ready)
- busy  out  1  high in FILL or DRAIN
- frame_done  out  1  one-cycle pulse when a frame's last result beat arrives
- frame_cnt  out  CNT_W  completed frames, wraps
- drop_cnt  out  CNT_W  decimated samples lost in FILL, saturates at all-ones

Behaviour:
- Reset (async, active-high): state=IDLE; out_valid=0, out_last=0, out_data=0, busy=0, frame_done=0, frame_cnt=0, drop_cnt=0; internal counters=0.
- State IDLE:
  - Decimation counter held at 0; in_valid ignored.
  - enable=1 -> FILL next cycle; issue_cnt and accept_cnt cleared.
- State FILL:
  - The decimation counter dec increments on every in_valid.
  - emit = in_valid && dec==2^DECIM_LOG2-1; dec wraps to 0.
  - When emit && issue_cnt<N_FFT && (!out_valid || out_ready):
    - load the output register next cycle;
    - out_data = {GUARD copies of in_data[W_IN-1], in_data, (W_OUT-W_IN-GUARD) zeros};
    - issue_cnt++;
    - out_last=1 iff this load is the N_FFT-th.
  - Latency is 1 cycle from the emitting in_valid to out_valid.
  - When emit occurs with issue_cnt<N_FFT but the output register is full and out_ready=0: the sample is dropped and drop_cnt++ (saturating). A drop does not advance issue_cnt.
  - out_valid && out_ready clears out_valid unless a new load occurs in the same cycle; the simultaneous load wins.
  - The handshake on the out_last word -> DRAIN next cycle, with out_valid=0 and out_last=0.
  - Emits after issue_cnt==N_FFT are discarded and not counted as drops.
- State DRAIN:
  - No outputs issued; decimated samples are discarded uncounted, and dec keeps running.
  - Each res_beat increments res_cnt.
  - On the N_FFT-th beat: frame_done=1 for one cycle, frame_cnt++ (wraps), res_cnt=0. Then enable=1 -> FILL (issue_cnt cleared, dec NOT cleared, preserving decimation phase across frames); enable=0 -> IDLE.
  - res_beat in IDLE or FILL is ignored.
- enable fall mid-frame: the current frame completes FILL and DRAIN, then the block goes to IDLE. enable has no effect until the next frame boundary.
- busy = (state!=IDLE), registered.
- Internal counter widths: issue_cnt/res_cnt sized $clog2(N_FFT)+1; dec sized DECIM_LOG2 (DECIM_LOG2=0 means no decimation; every in_valid emits).
- Reset mid-frame aborts immediately to IDLE; the FFT is reset by the same signal.

Decomposition:
- Shared package fft_seq_pkg: state enum (IDLE, FILL, DRAIN); localparams for the default N_FFT and default widths.
- One natural sub-module, sample_decimator: dec counter plus emit plus sign-extension/shift, with a clear input for IDLE.
- FSM, output register and statistics stay in the top.

Test Plan:
- Reset then enable=1, DECIM_LOG2=2, in_valid every cycle, in_data=16'h8001, out_ready=1:
  - first out_valid 4 cycles after the first in_valid; out_data=32'hFF800100;
  - exactly 1024 words issued, out_last on the 1024th only; busy=1.
- After FILL, pulse res_beat 1023 times -> no frame_done; 1024th beat -> frame_done for one cycle, frame_cnt=1, immediate return to FILL.
- out_ready=0 for 3 emit periods with out_valid=1 -> drop_cnt=3, issue_cnt unchanged, held out_data stable; on release, the frame still totals 1024 handshakes.
- enable deasserted at sample 500 -> remaining 524 samples issued, DRAIN completes, frame_done pulses, then IDLE with busy=0 and no further out_valid.
- Emit coincident with out_ready=1 and a full register -> no drop; the new word is presented the next cycle (back-to-back, DECIM_LOG2=0).
- Assert reset asynchronously mid-DRAIN (no clock edge) -> out_valid, busy, frame_cnt, drop_cnt go to 0 immediately; state=IDLE.
